i2c_slave: RTL and testbench
============================

# i2c_slave

I2C target (responder) block: answers a 7-bit address, accepts written bytes and returns read bytes over open-drain SCL/SDA. It sits opposite `i2c_master` on the same bus, uses the same `*_out`/`*_dir` pad convention (`dir=1` drives `out`, `dir=0` releases the line), and exposes byte-level strobes to local logic. Standard-mode timing at 12 MHz system clock. Clock stretching is optional.

## Interface
- `SLAVE_ADDR`, default 7'h42: own 7-bit address. General call is not supported.
- `SYNC_STAGES`, default 2: synchronizer depth for `scl_in`/`sda_in`, minimum 2.
- `clk`  in  1: system clock.
- `reset_n`  in  1: asynchronous, active-low reset.
- `scl_in`, `sda_in`  in  1: bus line levels (asynchronous).
- `sda_out`, `sda_dir`  out  1: SDA pad control. Only ever drives 0.
- `scl_out`, `scl_dir`  out  1: SCL pad control, used only for stretching.
- `rx_data`  out  8: last byte written by the master.
- `rx_valid`  out  1: 1-clk pulse when `rx_data` updates.
- `tx_data`  in  8: next byte to return on a read.
- `tx_ready`  in  1: `tx_data` valid. Used only when stretching is enabled.
- `tx_load`  out  1: 1-clk pulse when `tx_data` is sampled into the shifter.
- `start_det`, `stop_det`  out  1: 1-clk pulse per START/repeated START and per STOP.
- `master_nack`  out  1: 1-clk pulse when the master NACKs a read byte.
- `busy`  out  1: high from address match until STOP or NACK.

## Operation
- Line inputs pass through `SYNC_STAGES` flops. All edges are taken on synchronized values `scl_s`/`sda_s`.
- START: `sda_s` falls while `scl_s`=1. STOP: `sda_s` rises while `scl_s`=1. Both act in every state.
  - START jumps to ADDR and clears the bit counter.
  - STOP goes to IDLE and releases SDA.
- States: IDLE, ADDR, ADDR_ACK, RX_BYTE, RX_ACK, TX_BYTE, TX_ACK.
- Data sampling and driving:
  - Input bits are sampled on the `scl_s` rising edge, MSB first.
  - SDA is changed only on the `scl_s` falling edge.
- ADDR: shift in 8 bits. At the 8th falling edge:
  - If `addr[7:1]==SLAVE_ADDR`, drive SDA=0, set `busy`, latch R/W, go to ADDR_ACK.
  - Otherwise go to IDLE and ignore the bus until the next START.
- ADDR_ACK, at the falling edge ending the ACK clock:
  - Write (R/W=0): release SDA, go to RX_BYTE.
  - Read (R/W=1): load `tx_data` and pulse `tx_load`, drive bit 7, go to TX_BYTE.
- RX_BYTE: at the 8th falling edge, update `rx_data`, pulse `rx_valid`, drive SDA=0 (always ACK), go to RX_ACK.
- RX_ACK: at the next falling edge, release SDA and return to RX_BYTE.
- TX_BYTE:
  - Shift out one bit per falling edge. SDA is driven only for 0 bits; 1 bits release the line (`sda_dir`=0).
  - After bit 0's falling edge, release SDA and go to TX_ACK.
- TX_ACK: sample `sda_s` on the rising edge.
  - ACK (0): at the falling edge, load the next byte, pulse `tx_load`, go to TX_BYTE.
  - NACK (1): pulse `master_nack`, clear `busy`, go to IDLE and wait for STOP/START.

## Timing
- Reset values:
  - `sda_out`=1, `sda_dir`=0, `scl_out`=1, `scl_dir`=0.
  - `rx_data`=0.
  - `rx_valid`, `tx_load`, `start_det`, `stop_det`, `master_nack`, `busy` all 0.
  - State is IDLE.
- Reset asserted mid-transfer releases both lines immediately (asynchronous).
- Detection latency: `SYNC_STAGES`+1 clk from the pad edge to the strobe or SDA update. With defaults this is 3 clk (250 ns), well inside the 5 µs SCL low phase.
- `rx_valid` coincides with `rx_data` changing. `rx_data` then holds until the next byte.
- `tx_data` must be stable in the cycle `tx_load` pulses. The next `tx_data` is needed by the next ACK falling edge (≥1 byte time).
- Simultaneous START and STOP in one cycle cannot occur. A START overrides any pending ACK drive.
- The bit counter is 3 bits. Wrap from 7 to 0 marks the byte boundary.

## Configuration
- `I2C_SLAVE_STRETCH_EN` defined:
  - At any falling edge where a `tx_data` load is due and `tx_ready`=0, drive SCL low (`scl_out`=0, `scl_dir`=1).
  - Hold until `tx_ready`=1, then load, pulse `tx_load`, drive bit 7, release SCL after 1 clk.
- Not defined:
  - `scl_out`=1 and `scl_dir`=0 constantly.
  - `tx_ready` is ignored; the load is unconditional.

## Structure
- Shared package `i2c_pkg`, also used by `i2c_master`, holds:
  - state encodings, 3-bit;
  - `I2C_ADDR_W`=7 and `I2C_BYTE_W`=8;
  - the ACK=0/NACK=1 constants.
- One sub-module, `i2c_bus_sync`: line synchronizers, `scl_s` rise/fall strobes, START/STOP detection. Reusable by a stretching-aware master.

## Test plan
- Write: `i2c_master` sends addr 0x42 W, then 0xA5, 0x3C, STOP.
  - Expect 3 ACKs, `rx_valid` ×2 with `rx_data` 0xA5 then 0x3C.
  - Expect `start_det`/`stop_det` one pulse each, `busy` low after STOP.
- Read: addr 0x42 R with `tx_data` 0x5A then 0xC3; master ACKs the first byte and NACKs the second.
  - Expect master receives 0x5A, 0xC3.
  - Expect `tx_load` ×2 and `master_nack` ×1.
- Wrong address 0x43 W, 0xFF.
  - Expect NACK (SDA released at the 9th clock), no `rx_valid`, `busy`=0.
- Repeated START: write 0x11, then Sr + addr 0x42 R.
  - Expect `rx_data`=0x11, then a correct read of `tx_data`, and `start_det` ×2.
- `reset_n` low during bit 4 of a read byte.
  - Expect `sda_dir`=0 within the same cycle and all strobes 0.
  - Expect a fresh write after release to work normally.
- `I2C_SLAVE_STRETCH_EN`: read with `tx_ready`=0 for 200 clk.
  - Expect `scl_dir`=1 for about 200 clk, then byte 0x5A delivered intact.

Source files
------------

// File: rtl/i2c_pkg.sv
// rtl/i2c_pkg.sv - shared I2C constants and state encodings for i2c_slave and i2c_master
package i2c_pkg;

  localparam int I2C_ADDR_W = 7;
  localparam int I2C_BYTE_W = 8;

  localparam logic I2C_ACK  = 1'b0;
  localparam logic I2C_NACK = 1'b1;

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_ADDR     = 3'd1,
    ST_ADDR_ACK = 3'd2,
    ST_RX_BYTE  = 3'd3,
    ST_RX_ACK   = 3'd4,
    ST_TX_BYTE  = 3'd5,
    ST_TX_ACK   = 3'd6
  } i2c_state_e;

endpackage

// File: rtl/i2c_slave_if.sv
// rtl/i2c_slave_if.sv - open-drain SCL/SDA pad bundle (dir=1 drives out, dir=0 releases)
interface i2c_slave_if;

  logic scl_in;
  logic sda_in;
  logic scl_out;
  logic scl_dir;
  logic sda_out;
  logic sda_dir;

  modport slave (
    input  scl_in, sda_in,
    output scl_out, scl_dir, sda_out, sda_dir
  );

  modport master (
    output scl_in, sda_in,
    input  scl_out, scl_dir, sda_out, sda_dir
  );

endinterface

// File: rtl/i2c_bus_sync.sv
// rtl/i2c_bus_sync.sv - SCL/SDA synchronizers, SCL edge strobes, START/STOP detection
module i2c_bus_sync #(
  parameter int SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic reset_n,
  input  logic scl_in,
  input  logic sda_in,
  output logic scl_s,
  output logic sda_s,
  output logic scl_rise,
  output logic scl_fall,
  output logic start,
  output logic stop
);

  logic [SYNC_STAGES-1:0] scl_sync;
  logic [SYNC_STAGES-1:0] sda_sync;
  logic                   scl_q;
  logic                   sda_q;

  // Reset to the idle bus level so leaving reset never looks like an edge.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      scl_sync <= '1;
      sda_sync <= '1;
      scl_q    <= 1'b1;
      sda_q    <= 1'b1;
    end else begin
      scl_sync <= {scl_sync[SYNC_STAGES-2:0], scl_in};
      sda_sync <= {sda_sync[SYNC_STAGES-2:0], sda_in};
      scl_q    <= scl_s;
      sda_q    <= sda_s;
    end
  end

  assign scl_s    = scl_sync[SYNC_STAGES-1];
  assign sda_s    = sda_sync[SYNC_STAGES-1];
  assign scl_rise = scl_s & ~scl_q;
  assign scl_fall = ~scl_s & scl_q;
  assign start    = scl_s & scl_q & sda_q & ~sda_s;
  assign stop     = scl_s & scl_q & ~sda_q & sda_s;

endmodule

// File: rtl/i2c_slave.sv
// rtl/i2c_slave.sv - I2C target with byte strobes; clock stretching under I2C_SLAVE_STRETCH_EN
module i2c_slave
  import i2c_pkg::*;
#(
  parameter logic [I2C_ADDR_W-1:0] SLAVE_ADDR  = 7'h42,
  parameter int                    SYNC_STAGES = 2
) (
  input  logic                  clk,
  input  logic                  reset_n,
  i2c_slave_if.slave            bus,
  output logic [I2C_BYTE_W-1:0] rx_data,
  output logic                  rx_valid,
  input  logic [I2C_BYTE_W-1:0] tx_data,
  input  logic                  tx_ready,
  output logic                  tx_load,
  output logic                  start_det,
  output logic                  stop_det,
  output logic                  master_nack,
  output logic                  busy
);

  i2c_state_e state, state_nx;

  logic                  unused_scl_s;
  logic                  sda_s, scl_rise, scl_fall, bus_start, bus_stop;
  logic [2:0]            bit_cnt;
  logic                  byte_full, rw, ack_bit;
  logic                  sda_drv, sda_drv_nx;
  logic [I2C_BYTE_W-1:0] shreg, txsh;
  logic                  tx_due, load_go, rx_go, nack_go, match_go, miss_go;
  logic                  addr_hit, counting, scl_hold, ready_ok;

  i2c_bus_sync #(.SYNC_STAGES(SYNC_STAGES)) u_sync (
    .clk      (clk),
    .reset_n  (reset_n),
    .scl_in   (bus.scl_in),
    .sda_in   (bus.sda_in),
    .scl_s    (unused_scl_s),
    .sda_s    (sda_s),
    .scl_rise (scl_rise),
    .scl_fall (scl_fall),
    .start    (bus_start),
    .stop     (bus_stop)
  );

  assign addr_hit = (shreg[7:1] == SLAVE_ADDR);
  assign counting = (state == ST_ADDR) || (state == ST_RX_BYTE) || (state == ST_TX_BYTE);

`ifdef I2C_SLAVE_STRETCH_EN
  logic hold_set, load_q;

  assign ready_ok = tx_ready;
  assign hold_set = scl_fall & tx_due & ~tx_ready;

  // SCL is let go one clk after the load so bit 7 is settled before the line rises.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      scl_hold <= 1'b0;
      load_q   <= 1'b0;
    end else begin
      load_q <= load_go;
      if (bus_start || bus_stop) scl_hold <= 1'b0;
      else if (hold_set)         scl_hold <= 1'b1;
      else if (load_q)           scl_hold <= 1'b0;
    end
  end
`else
  logic unused_tx_ready;

  assign unused_tx_ready = tx_ready;
  assign ready_ok        = 1'b1;
  assign scl_hold        = 1'b0;
`endif

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state <= ST_IDLE;
    else          state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    if (bus_start)     state_nx = ST_ADDR;
    else if (bus_stop) state_nx = ST_IDLE;
    else begin
      case (state)
        ST_ADDR:     if (scl_fall && byte_full) state_nx = addr_hit ? ST_ADDR_ACK : ST_IDLE;
        ST_ADDR_ACK: if (load_go) state_nx = ST_TX_BYTE;
                     else if (scl_fall && !rw) state_nx = ST_RX_BYTE;
        ST_RX_BYTE:  if (scl_fall && byte_full) state_nx = ST_RX_ACK;
        ST_RX_ACK:   if (scl_fall) state_nx = ST_RX_BYTE;
        ST_TX_BYTE:  if (scl_fall && byte_full) state_nx = ST_TX_ACK;
        ST_TX_ACK:   if (load_go) state_nx = ST_TX_BYTE;
                     else if (nack_go) state_nx = ST_IDLE;
        default:     state_nx = state;
      endcase
    end
  end

  // Per-state actions; START/STOP always win and release SDA.
  always_comb begin
    sda_drv_nx = sda_drv;
    tx_due     = 1'b0;
    rx_go      = 1'b0;
    nack_go    = 1'b0;
    match_go   = 1'b0;
    miss_go    = 1'b0;
    if (bus_start || bus_stop) begin
      sda_drv_nx = 1'b0;
    end else begin
      case (state)
        ST_ADDR:
          if (scl_fall && byte_full) begin
            if (addr_hit) begin
              match_go   = 1'b1;
              sda_drv_nx = 1'b1;
            end else begin
              miss_go = 1'b1;
            end
          end
        ST_ADDR_ACK: begin
          if (scl_fall) sda_drv_nx = 1'b0;
          if ((scl_fall || scl_hold) && rw) tx_due = 1'b1;
        end
        ST_RX_BYTE:
          if (scl_fall && byte_full) begin
            rx_go      = 1'b1;
            sda_drv_nx = 1'b1;
          end
        ST_RX_ACK:
          if (scl_fall) sda_drv_nx = 1'b0;
        ST_TX_BYTE:
          if (scl_fall) sda_drv_nx = byte_full ? 1'b0 : ~txsh[6];
        ST_TX_ACK:
          if (scl_fall || scl_hold) begin
            if (ack_bit == I2C_ACK) tx_due = 1'b1;
            else if (scl_fall)      nack_go = 1'b1;
          end
        default: sda_drv_nx = sda_drv;
      endcase
      if (tx_due && ready_ok) sda_drv_nx = ~tx_data[7];
    end
  end

  assign load_go = tx_due & ready_ok;
  assign tx_load = load_go;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      bit_cnt     <= 3'd0;
      byte_full   <= 1'b0;
      shreg       <= '0;
      txsh        <= '0;
      rw          <= 1'b0;
      ack_bit     <= I2C_NACK;
      sda_drv     <= 1'b0;
      rx_data     <= '0;
      rx_valid    <= 1'b0;
      start_det   <= 1'b0;
      stop_det    <= 1'b0;
      master_nack <= 1'b0;
      busy        <= 1'b0;
    end else begin
      start_det   <= bus_start;
      stop_det    <= bus_stop;
      rx_valid    <= rx_go;
      master_nack <= nack_go;
      sda_drv     <= sda_drv_nx;

      // The 7->0 wrap marks a full byte, consumed by the following falling edge.
      if (bus_start) begin
        bit_cnt   <= 3'd0;
        byte_full <= 1'b0;
      end else if (scl_rise && counting) begin
        bit_cnt   <= bit_cnt + 3'd1;
        byte_full <= (bit_cnt == 3'd7);
      end else if (scl_fall) begin
        byte_full <= 1'b0;
      end

      if (scl_rise && (state == ST_ADDR || state == ST_RX_BYTE)) shreg <= {shreg[6:0], sda_s};
      if (scl_rise && state == ST_TX_ACK) ack_bit <= sda_s;
      if (match_go) rw <= shreg[0];
      if (rx_go)    rx_data <= shreg;

      if (load_go) txsh <= tx_data;
      else if (state == ST_TX_BYTE && scl_fall && !byte_full) txsh <= {txsh[6:0], 1'b0};

      if (bus_stop || nack_go || miss_go) busy <= 1'b0;
      else if (match_go)                  busy <= 1'b1;
    end
  end

  assign bus.sda_dir = sda_drv;
  assign bus.sda_out = ~sda_drv;
  assign bus.scl_dir = scl_hold;
  assign bus.scl_out = ~scl_hold;

endmodule

// File: tb/tb_i2c_slave.sv
// tb/tb_i2c_slave.sv - randomized scoreboard bench for i2c_slave with a bit-level bus master
module tb_i2c_slave;
  import i2c_pkg::*;

  localparam logic [6:0] OWN = 7'h42;
  localparam int         Q   = 8;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  always #5 clk = ~clk;

  i2c_slave_if bus();

  logic m_scl = 1'b1;
  logic m_sda = 1'b1;
  assign bus.scl_in = m_scl & ~(bus.scl_dir & ~bus.scl_out);
  assign bus.sda_in = m_sda & ~(bus.sda_dir & ~bus.sda_out);

  logic [7:0] rx_data, tx_data;
  logic       rx_valid, tx_ready, tx_load, start_det, stop_det, master_nack, busy;

  i2c_slave #(.SLAVE_ADDR(OWN), .SYNC_STAGES(2)) dut (
    .clk         (clk),
    .reset_n     (reset_n),
    .bus         (bus),
    .rx_data     (rx_data),
    .rx_valid    (rx_valid),
    .tx_data     (tx_data),
    .tx_ready    (tx_ready),
    .tx_load     (tx_load),
    .start_det   (start_det),
    .stop_det    (stop_det),
    .master_nack (master_nack),
    .busy        (busy)
  );

  int total = 0;
  int bad   = 0;

  logic [7:0] exp_rx[$];
  logic [7:0] tx_list[64];
  logic [7:0] wdat[4];
  int tx_idx = 0;
  int n_start = 0, n_stop = 0, n_load = 0, n_nack = 0, n_hold = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Monitor: pops the scoreboard on every rx_valid, counts strobes.
  initial forever begin
    @(negedge clk);
    if (reset_n) begin
      if (rx_valid) begin
        if (exp_rx.size() == 0) begin
          total++;
          bad++;
          $display("FAIL rx_unexpected: got %02h expected no byte", rx_data);
        end else begin
          chk("rx_data", rx_data, exp_rx.pop_front());
        end
      end
      if (start_det)   n_start++;
      if (stop_det)    n_stop++;
      if (master_nack) n_nack++;
      if (bus.scl_dir) n_hold++;
    end
  end

  // Local tx source: presents tx_list in order, advancing after each load.
  initial forever begin
    @(negedge clk);
    if (tx_load) begin
      n_load++;
      @(posedge clk);
      #1;
      tx_idx  = tx_idx + 1;
      tx_data = tx_list[tx_idx % 64];
    end
  end

  initial begin
    #1500000;
    $display("FAIL watchdog: simulation exceeded time bound");
    $fatal(1, "watchdog");
  end

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic scl_up();
    int w;
    w = 0;
    m_scl = 1'b1;
    while (!bus.scl_in && w < 5000) begin
      @(negedge clk);
      w++;
    end
    if (!bus.scl_in) begin
      total++;
      bad++;
      $display("FAIL scl_release: got low after %0d clk expected high", w);
    end
  endtask

  task automatic bit_x(input logic b, output logic r);
    m_sda = b;
    tick(Q);
    scl_up();
    tick(Q);
    r = bus.sda_in;
    tick(Q);
    m_scl = 1'b0;
    tick(Q);
  endtask

  task automatic do_start();
    m_sda = 1'b1;
    tick(Q);
    scl_up();
    tick(Q);
    m_sda = 1'b0;
    tick(Q);
    m_scl = 1'b0;
    tick(Q);
  endtask

  task automatic do_stop();
    m_sda = 1'b0;
    tick(Q);
    scl_up();
    tick(Q);
    m_sda = 1'b1;
    tick(Q);
  endtask

  task automatic wr_byte(input logic [7:0] d, output logic a);
    logic r;
    for (int i = 7; i >= 0; i--) bit_x(d[i], r);
    bit_x(1'b1, a);
  endtask

  task automatic rd_byte(input logic ack, output logic [7:0] d);
    logic r;
    d = '0;
    for (int i = 7; i >= 0; i--) begin
      bit_x(1'b1, r);
      d[i] = r;
    end
    bit_x(ack, r);
  endtask

  // Reference: own address is ACKed and every data byte reaches rx_data; others are ignored.
  task automatic write_body(input logic [6:0] a, input int n);
    logic ak;
    bit   hit;
    hit = (a == OWN);
    wr_byte({a, 1'b0}, ak);
    chk("addr_ack", ak, hit ? I2C_ACK : I2C_NACK);
    chk("busy_after_addr", busy, hit);
    for (int k = 0; k < n; k++) begin
      if (hit) exp_rx.push_back(wdat[k]);
      wr_byte(wdat[k], ak);
      chk("data_ack", ak, hit ? I2C_ACK : I2C_NACK);
    end
  endtask

  // Reference: a read returns the tx source in order, one load per byte, last byte NACKed.
  task automatic read_body(input int n);
    logic       ak;
    logic [7:0] d;
    int         base, l0, k0;
    base = tx_idx;
    l0   = n_load;
    k0   = n_nack;
    wr_byte({OWN, 1'b1}, ak);
    chk("rd_addr_ack", ak, I2C_ACK);
    for (int k = 0; k < n; k++) begin
      rd_byte((k == n - 1) ? I2C_NACK : I2C_ACK, d);
      chk("rd_data", d, tx_list[(base + k) % 64]);
    end
    chk("tx_load_count", n_load - l0, n);
    chk("master_nack_count", n_nack - k0, 1);
    chk("busy_after_nack", busy, 0);
  endtask

  task automatic finish_checks(input int s0, input int p0, input int starts);
    chk("start_count", n_start - s0, starts);
    chk("stop_count", n_stop - p0, 1);
    chk("busy_after_stop", busy, 0);
    chk("rx_missing", exp_rx.size(), 0);
  endtask

  task automatic run_write(input logic [6:0] a, input int n);
    int s0, p0;
    s0 = n_start;
    p0 = n_stop;
    do_start();
    write_body(a, n);
    do_stop();
    finish_checks(s0, p0, 1);
  endtask

  task automatic run_read(input int n);
    int s0, p0;
    s0 = n_start;
    p0 = n_stop;
    do_start();
    read_body(n);
    do_stop();
    finish_checks(s0, p0, 1);
  endtask

  initial begin
    logic       ak, r;
    logic [6:0] a;
    int         s0, p0, n, kind;
    for (int i = 0; i < 64; i++) tx_list[i] = 8'($urandom);
    tx_list[0] = 8'h5A;
    tx_list[1] = 8'hC3;
    tx_data    = tx_list[0];
    tx_ready   = 1'b1;
    reset_n    = 1'b0;
    tick(4);

    chk("rst_sda_dir", bus.sda_dir, 0);
    chk("rst_sda_out", bus.sda_out, 1);
    chk("rst_scl_dir", bus.scl_dir, 0);
    chk("rst_scl_out", bus.scl_out, 1);
    chk("rst_rx_data", rx_data, 0);
    chk("rst_strobes", {rx_valid, tx_load, start_det, stop_det, master_nack, busy}, 0);
    reset_n = 1'b1;
    tick(10);

    wdat[0] = 8'hA5;
    wdat[1] = 8'h3C;
    run_write(OWN, 2);
    chk("rx_hold", rx_data, 8'h3C);

    run_read(2);

    wdat[0] = 8'hFF;
    run_write(7'h43, 1);

    s0 = n_start;
    p0 = n_stop;
    wdat[0] = 8'h11;
    do_start();
    write_body(OWN, 1);
    do_start();
    read_body(1);
    do_stop();
    finish_checks(s0, p0, 2);
    chk("rx_after_sr", rx_data, 8'h11);

    // Reset during bit 4 of a read byte whose bit 4 is 0, so SDA is being driven.
    tx_list[tx_idx % 64] = tx_list[tx_idx % 64] & 8'hEF;
    tx_data = tx_list[tx_idx % 64];
    do_start();
    wr_byte({OWN, 1'b1}, ak);
    chk("rst_test_addr_ack", ak, I2C_ACK);
    for (int i = 0; i < 3; i++) bit_x(1'b1, r);
    m_sda = 1'b1;
    tick(Q);
    scl_up();
    tick(2);
    chk("drive_before_reset", bus.sda_dir, 1);
    #2;
    reset_n = 1'b0;
    #1;
    chk("async_rst_sda_dir", bus.sda_dir, 0);
    chk("async_rst_strobes", {rx_valid, tx_load, start_det, stop_det, master_nack, busy}, 0);
    m_sda = 1'b1;
    tick(4);
    reset_n = 1'b1;
    tick(10);
    wdat[0] = 8'($urandom);
    wdat[1] = 8'($urandom);
    run_write(OWN, 2);

`ifdef I2C_SLAVE_STRETCH_EN
    begin
      int h0, w;
      tx_list[tx_idx % 64] = 8'h5A;
      tx_data  = tx_list[tx_idx % 64];
      tx_ready = 1'b0;
      h0 = n_hold;
      fork
        begin
          w = 0;
          while (!bus.scl_dir && w < 20000) begin
            @(negedge clk);
            w++;
          end
          repeat (200) @(negedge clk);
          tx_ready = 1'b1;
        end
        run_read(1);
      join
      chk("stretch_len_ok", (n_hold - h0 >= 195) && (n_hold - h0 <= 210), 1);
    end
`endif

    for (int t = 0; t < 10; t++) begin
      kind = $urandom_range(0, 2);
      n    = $urandom_range(1, 3);
      for (int k = 0; k < 4; k++) wdat[k] = 8'($urandom);
      if (kind == 0) begin
        run_write(OWN, n);
      end else if (kind == 1) begin
        run_read(n);
      end else begin
        a = 7'($urandom_range(0, 127));
        if (a == OWN) a = a ^ 7'h01;
        run_write(a, n);
      end
    end

    tick(10);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
